register_serializer: RTL and testbench

- Transmit-side companion to the register datapath.
- Accepts a parallel DATA_WIDTH-bit word on a valid/ready handshake and shifts it out one bit per handshake on a serial valid/ready stream.
- A one-word holding buffer lets the next word stream out back-to-back with no idle cycle.
- Sits between the register output and any bit-serial consumer (link, scan chain, test monitor).

---
 rtl/register_serializer.sv | 64 ++++++
 tb/tb_register_serializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/register_serializer.sv
// register_serializer: parallel word to bit-serial stream with a one-word holding buffer
module register_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter bit MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ser_data,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  ser_first,
  output logic                  ser_last,
  output logic                  busy,
  output logic [15:0]           words_sent
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_d;
  logic [DATA_WIDTH-1:0] hold, sh;
  logic hold_valid, accept, hs, at_last, load;
  logic [CW-1:0] cnt;
  assign in_ready = !rst && !hold_valid;
  assign ser_valid = state == SHIFT;
  assign ser_data = ser_valid && (MSB_FIRST ? sh[DATA_WIDTH-1] : sh[0]);
  assign ser_first = ser_valid && cnt == '0;
  assign ser_last = ser_valid && at_last;
  assign busy = ser_valid || hold_valid;
  // the held word enters the shifter either from idle or right behind the last bit
  always_comb begin
    accept = in_valid && in_ready;
    hs = ser_valid && ser_ready;
    at_last = cnt == CW'(DATA_WIDTH - 1);
    load = hold_valid && (state == IDLE || (hs && at_last));
    state_d = load ? SHIFT : (hs && at_last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold <= '0;
      hold_valid <= 1'b0;
      sh <= '0;
      cnt <= '0;
      words_sent <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        hold <= data_in;
        hold_valid <= 1'b1;
      end
      if (load) begin
        sh <= hold;
        hold_valid <= 1'b0;
        cnt <= '0;
      end else if (hs && !at_last) begin
        sh <= MSB_FIRST ? sh << 1 : sh >> 1;
        cnt <= cnt + 1'b1;
      end
      if (hs && at_last) words_sent <= words_sent + 16'd1;
    end
  end
endmodule

// File: tb/tb_register_serializer.sv
// tb_register_serializer: directed checks of an MSB-first and an LSB-first serializer
module tb_register_serializer;
  logic clk = 0, rst = 1, in_valid = 0, ser_ready = 1;
  logic [15:0] data_in = '0;
  logic in_ready, ser_data, ser_valid, ser_first, ser_last, busy;
  logic [15:0] words_sent;
  logic in_ready_l, ser_data_l, ser_valid_l, ser_first_l, ser_last_l, busy_l;
  logic [15:0] words_sent_l;

  register_serializer #(.DATA_WIDTH(16), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_first(ser_first),
    .ser_last(ser_last), .busy(busy), .words_sent(words_sent));

  register_serializer #(.DATA_WIDTH(16), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready_l),
    .ser_data(ser_data_l), .ser_valid(ser_valid_l), .ser_ready(ser_ready), .ser_first(ser_first_l),
    .ser_last(ser_last_l), .busy(busy_l), .words_sent(words_sent_l));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  // per-cycle logs, cycle c stored at bit 63-c so a window reads in time order
  logic [63:0] v_log, d_log, dl_log, f_log, l_log, ir_log, b_log;
  int c_log[64], ws_log[64];
  int acc[$];
  logic [15:0] txq[$], rx[$], rxl[$];
  logic [15:0] cur, curl;
  int st_from = 0, st_to = 0, rst_at = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pk(input logic [63:0] x, input int s);
    return x[63-s -: 16];
  endfunction

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic run(input int n);
    {v_log, d_log, dl_log, f_log, l_log, ir_log, b_log} = '0;
    acc.delete(); rx.delete(); rxl.delete();
    cur = '0; curl = '0;
    for (int c = 0; c < n; c++) begin
      rst = (c == rst_at);
      ser_ready = !(c >= st_from && c < st_to);
      in_valid = txq.size() > 0;
      data_in = in_valid ? txq[0] : 16'h0;
      #1;
      v_log[63-c] = ser_valid; d_log[63-c] = ser_data; dl_log[63-c] = ser_data_l;
      f_log[63-c] = ser_first; l_log[63-c] = ser_last;
      ir_log[63-c] = in_ready; b_log[63-c] = busy;
      c_log[c] = int'(dut.cnt); ws_log[c] = int'(words_sent);
      if (!rst) begin
        if (in_valid && in_ready) begin
          acc.push_back(c);
          void'(txq.pop_front());
        end
        if (ser_valid && ser_ready) begin
          cur = {cur[14:0], ser_data};
          if (ser_last) rx.push_back(cur);
        end
        if (ser_valid_l && ser_ready) begin
          curl = {ser_data_l, curl[15:1]};
          if (ser_last_l) rxl.push_back(curl);
        end
      end
      @(posedge clk); #1;
    end
    rst = 0; in_valid = 0; ser_ready = 1;
    st_from = 0; st_to = 0; rst_at = -1;
  endtask

  initial begin
    #1;
    check("in_ready_in_rst", in_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_ser_data", ser_data, 0);
    check("rst_flags", {ser_first, ser_last}, 0);
    check("rst_busy", busy, 0);
    check("rst_words", words_sent, 0);

    // basic
    txq = '{16'hA5C3};
    run(20);
    check("basic_acc", acc.size() > 0 ? acc[0] : -1, 0);
    check("basic_gap", v_log[63-1], 0);
    check("basic_bits", pk(d_log, 2), 16'hA5C3);
    check("basic_valid", pk(v_log, 2), 16'hFFFF);
    check("basic_first", pk(f_log, 2), 16'h8000);
    check("basic_last", pk(l_log, 2), 16'h0001);
    check("basic_after", v_log[63-18], 0);
    check("basic_words", words_sent, 1);
    check("basic_busy", busy, 0);

    // back-to-back
    do_reset();
    txq = '{16'h0001, 16'h8000};
    run(40);
    check("b2b_acc1", acc.size() > 1 ? acc[1] : -1, 2);
    check("b2b_valid_a", pk(v_log, 2), 16'hFFFF);
    check("b2b_valid_b", pk(v_log, 18), 16'hFFFF);
    check("b2b_bits_a", pk(d_log, 2), 16'h0001);
    check("b2b_bits_b", pk(d_log, 18), 16'h8000);
    check("b2b_first_a", pk(f_log, 2), 16'h8000);
    check("b2b_first_b", pk(f_log, 18), 16'h8000);
    check("b2b_end", v_log[63-34], 0);
    check("b2b_words", words_sent, 2);

    // backpressure on bit 5 (cycle 7) for three cycles
    do_reset();
    txq = '{16'hFFFE};
    st_from = 7; st_to = 10;
    run(24);
    check("bp_cnt7", c_log[7], 5);
    check("bp_cnt9", c_log[9], 5);
    check("bp_cnt10", c_log[10], 5);
    check("bp_data", d_log[63-7 -: 4], 4'hF);
    check("bp_valid", v_log[63-7 -: 4], 4'hF);
    check("bp_flags", {f_log[63-7 -: 4], l_log[63-7 -: 4]}, 8'h00);
    check("bp_last_at", l_log[63-20], 1);
    check("bp_word", rx.size() > 0 ? rx[0] : 16'hDEAD, 16'hFFFE);
    check("bp_idle", v_log[63-21], 0);
    check("bp_words", words_sent, 1);

    // holding buffer full with three queued words
    do_reset();
    txq = '{16'h1111, 16'h2222, 16'h3333};
    run(55);
    check("hb_acc1", acc.size() > 1 ? acc[1] : -1, 2);
    check("hb_acc2", acc.size() > 2 ? acc[2] : -1, 18);
    check("hb_ready_low", pk(ir_log, 2), 16'h8000);
    check("hb_ready_back", ir_log[63-18], 1);
    check("hb_last1", l_log[63-17], 1);
    check("hb_rx_n", rx.size(), 3);
    check("hb_rx2", rx.size() > 2 ? rx[2] : 16'hDEAD, 16'h3333);
    check("hb_words", words_sent, 3);

    // reset while bit 7 of 16'h1234 is on the line, second word held
    txq = '{16'h1234, 16'h5678};
    rst_at = 9;
    run(30);
    check("rmw_cnt", c_log[9], 7);
    check("rmw_ws_before", ws_log[9], 3);
    check("rmw_valid", v_log[63-10], 0);
    check("rmw_busy", b_log[63-10], 0);
    check("rmw_ws", ws_log[10], 0);
    check("rmw_ready", ir_log[63-10], 1);
    check("rmw_quiet", {pk(v_log, 10), pk(v_log, 14)}, 32'h0);
    check("rmw_rx", rx.size(), 0);

    // LSB-first instance
    do_reset();
    txq = '{16'h0003};
    run(20);
    check("lsb_bits", pk(dl_log, 2), 16'hC000);
    check("lsb_word", rxl.size() > 0 ? rxl[0] : 16'hDEAD, 16'h0003);
    check("lsb_msb_word", rx.size() > 0 ? rx[0] : 16'hDEAD, 16'h0003);
    check("lsb_words", words_sent_l, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
